idft_frame_collector: RTL and testbench
=======================================

# idft_frame_collector

Downstream stage of the LLKI-wrapped IDFT core. It watches the core's `next_out` strobe and captures each output frame, presented as four 16-bit samples per cycle on `Y0`..`Y3`, into a two-frame ping-pong buffer. Completed frames are then drained over a valid/ready word stream toward the host/bus side. It decouples the IDFT's fixed-rate streaming output from a possibly stalling consumer, and flags dropped frames and protocol errors.

## Interface
Parameters:
- `FRAME_BEATS`, default 16: cycles per IDFT output frame (16 × 4 samples = 64-point frame); legal range 2..256.
- `DATA_W`, default 16: sample width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `next_out`  in  1  IDFT frame strobe; first output beat appears the cycle after.
- `Y0`,`Y1`,`Y2`,`Y3`  in  DATA_W each  IDFT output samples.
- `out_valid`  out  1  a completed frame word is available.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `out_data`  out  4*DATA_W  `{Y3,Y2,Y1,Y0}` of the current word.
- `out_last`  out  1  current word is beat FRAME_BEATS-1 of its frame.
- `frames_avail`  out  2  completed, not-fully-drained frames (0..2).
- `overflow`  out  1  sticky: a frame was dropped.
- `proto_err`  out  1  sticky: `next_out` arrived mid-frame.
- `err_clr`  in  1  one-cycle pulse; clears both sticky flags.

## Operation
- Storage: two banks of FRAME_BEATS × 4*DATA_W flops. Write pointer `wbank` and read pointer `rbank` each toggle on use. The beat counters `wbeat`/`rbeat` are clog2(FRAME_BEATS) bits wide.
- Capture FSM:
  - IDLE: `next_out` with a free bank → CAPTURE, `wbeat` = 0. `next_out` with no free bank → stays IDLE, sets `overflow`; the entire frame is dropped and nothing is written.
  - CAPTURE: writes `{Y3,Y2,Y1,Y0}` to `wbank[wbeat]` every cycle, with no stalls, and increments `wbeat`. On `wbeat == FRAME_BEATS-1` it marks the bank complete, toggles `wbank`, and returns to IDLE.
  - `next_out` on the last CAPTURE beat is a legal back-to-back start, evaluated like IDLE. It goes directly to CAPTURE with no gap if a bank is free; otherwise it sets `overflow` and goes to IDLE.
  - `next_out` on any other CAPTURE beat is ignored for framing and sets `proto_err`. The current capture continues unaffected.
- Free-bank rule: a start is accepted iff the number of banks occupied after this cycle, excluding the new frame, is < 2. A bank is occupied if it is completed or being captured. A bank is released in the same cycle its last word is popped, so a pop of `out_last` coincident with `next_out` frees a bank for that start.
- Drain: `out_valid = (frames_avail != 0)`. `out_data` is read combinationally from `rbank[rbeat]`. On a pop, `rbeat` increments; when `out_last` is popped, `rbeat` resets to 0, `rbank` toggles, and `frames_avail` decrements.
- `frames_avail` update: +1 on capture completion, −1 on a last-word pop, unchanged when both happen in the same cycle. It never exceeds 2.
- Sticky flags: set has priority over `err_clr` in the same cycle.
- `reset` mid-frame: the FSM goes to IDLE, all pointers and counters go to 0, and buffered data is discarded. Bank contents need not be cleared.

## Timing
- Values after reset: `out_valid`=0, `out_last`=0, `frames_avail`=0, `overflow`=0, `proto_err`=0. `out_data` is don't-care while `out_valid`=0.
- `next_out` at cycle T: beats are captured at T+1..T+FRAME_BEATS, and `out_valid` rises at T+FRAME_BEATS+1.
- Drain throughput is 1 word/cycle with `out_ready` held high. `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- Capture never back-pressures the IDFT. Loss occurs only through `overflow`.

## Test plan
- Single frame: with `Y0`..`Y3` = beat index + {0,0x100,0x200,0x300}, pulse `next_out` at T and hold `out_ready`=1. Required: `out_valid` rises at T+17; 16 words come out in order; `out_last` asserts on word 15 only; `frames_avail` goes 1→0.
- Back-to-back: pulse `next_out` at T and again at T+16, with `out_ready`=0. Required: `frames_avail`=2 at T+33. Draining then yields frame A followed by frame B with no corruption and `overflow`=0.
- Overflow: with 2 frames held and `out_ready`=0, pulse `next_out`. Required: `overflow`=1 and the held frames are unchanged. Drain both, then `err_clr` → `overflow`=0.
- Pop/start coincidence: with 2 frames held, pop the last word of the first frame in the same cycle as `next_out`. Required: the new frame is captured, `overflow`=0, and `frames_avail` = 1 then 2.
- Protocol error: pulse `next_out` at T, then again at T+5. Required: `proto_err`=1 and the frame still completes at T+16 with the correct data.
- Reset mid-capture: assert `reset` at T+8. Required: all outputs go to reset values on the next edge, and a fresh frame afterward drains correctly.

Source files
------------

// File: rtl/idft_frame_collector_if.sv
// Bundles the IDFT sample input, the drained word stream and the status/error
// signals of idft_frame_collector. The collector uses the slave modport.
interface idft_frame_collector_if #(
  parameter int DATA_W = 16
);
  logic                  next_out;
  logic [DATA_W-1:0]     Y0;
  logic [DATA_W-1:0]     Y1;
  logic [DATA_W-1:0]     Y2;
  logic [DATA_W-1:0]     Y3;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic                  out_last;
  logic [1:0]            frames_avail;
  logic                  overflow;
  logic                  proto_err;
  logic                  err_clr;
  // Capture FSM state for checkers: 0 = IDLE, 1 = CAPTURE.
  logic                  fsm_state;

  modport slave (
    input  next_out, Y0, Y1, Y2, Y3, out_ready, err_clr,
    output out_valid, out_data, out_last, frames_avail, overflow, proto_err,
    fsm_state
  );

  modport master (
    output next_out, Y0, Y1, Y2, Y3, out_ready, err_clr,
    input  out_valid, out_data, out_last, frames_avail, overflow, proto_err,
    fsm_state
  );
endinterface

// File: rtl/idft_frame_collector.sv
// Captures fixed-rate IDFT output frames into a two-bank ping-pong buffer and
// drains completed frames one word per cycle over a valid/ready stream.
module idft_frame_collector #(
  parameter int FRAME_BEATS = 16,
  parameter int DATA_W      = 16
) (
  input logic                   clk,
  input logic                   reset,
  idft_frame_collector_if.slave bus
);
  localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t              state;
  logic                wbank;
  logic                rbank;
  logic [BW-1:0]       wbeat;
  logic [BW-1:0]       rbeat;
  logic [1:0]          frames_avail;
  logic                overflow;
  logic                proto_err;
  logic [4*DATA_W-1:0] mem [2][FRAME_BEATS];

  logic       pop;
  logic       pop_last;
  logic       cap_last;
  logic       start_req;
  logic       bank_free;
  logic [1:0] held_next;

  // Stream handshake: a word transfers on any cycle where out_valid and
  // out_ready are both high; out_data/out_last hold until that happens.
  assign pop       = bus.out_valid && bus.out_ready;
  assign pop_last  = pop && (rbeat == LAST_BEAT);
  assign cap_last  = (state == CAPTURE) && (wbeat == LAST_BEAT);
  assign start_req = bus.next_out && ((state == IDLE) || cap_last);

  // Completed frames held after this edge; a frame finishing now counts, a
  // frame whose last word leaves now does not. This is also next frames_avail.
  assign held_next = frames_avail + {1'b0, cap_last} - {1'b0, pop_last};
  assign bank_free = (held_next < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      wbeat        <= '0;
      rbeat        <= '0;
      frames_avail <= 2'd0;
      overflow     <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      frames_avail <= held_next;

      if (pop) begin
        rbeat <= pop_last ? '0 : rbeat + BW'(1);
      end
      if (pop_last) begin
        rbank <= ~rbank;
      end

      if (state == CAPTURE) begin
        wbeat <= wbeat + BW'(1);
        if (cap_last) begin
          wbank <= ~wbank;
        end
      end

      // A start on the final capture beat chains straight into the next frame.
      if (start_req) begin
        if (bank_free) begin
          state <= CAPTURE;
          wbeat <= '0;
        end else begin
          state <= IDLE;
        end
      end else if (cap_last) begin
        state <= IDLE;
      end

      overflow  <= (start_req && !bank_free) || (overflow && !bus.err_clr);
      proto_err <= (bus.next_out && (state == CAPTURE) && !cap_last)
                   || (proto_err && !bus.err_clr);
    end
  end

  // Sample storage carries no reset; stale contents are never presented valid.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      mem[wbank][wbeat] <= {bus.Y3, bus.Y2, bus.Y1, bus.Y0};
    end
  end

  assign bus.out_valid    = (frames_avail != 2'd0);
  assign bus.out_data     = mem[rbank][rbeat];
  assign bus.out_last     = bus.out_valid && (rbeat == LAST_BEAT);
  assign bus.frames_avail = frames_avail;
  assign bus.overflow     = overflow;
  assign bus.proto_err    = proto_err;
  assign bus.fsm_state    = (state == CAPTURE);
endmodule

// File: tb/tb_idft_frame_collector.sv
// Self-checking bench for idft_frame_collector: directed scenarios plus random
// traffic, all compared against a word-queue reference model every cycle.
module tb_idft_frame_collector;
  localparam int FB     = 16;
  localparam int DATA_W = 16;
  localparam int W      = 4 * DATA_W;

  logic clk;
  logic reset;

  idft_frame_collector_if #(.DATA_W(DATA_W)) bus ();

  idft_frame_collector #(.FRAME_BEATS(FB), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];    // completed, not yet drained words in drain order
  logic [W-1:0] cap_buf[$];  // words of the frame currently being captured
  int           cap_left;    // beats still to capture (0 = not capturing)
  bit           m_ovf;
  bit           m_pe;

  int n_checks;
  int n_fail;

  bit          rand_y;
  logic [15:0] beat_ctr;
  logic [15:0] frame_no;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames are lists of words; occupancy is the number of
  // partially or fully undrained frames, and capture is a countdown.
  task automatic model_step(input bit nxt, input bit rdy, input bit clr,
                            input bit rst, input logic [W-1:0] word);
    bit was_cap;
    bit fin;
    bit ov_set;
    bit pe_set;
    int held;
    if (rst) begin
      exp_q.delete();
      cap_buf.delete();
      cap_left = 0;
      m_ovf    = 1'b0;
      m_pe     = 1'b0;
      return;
    end
    ov_set = 1'b0;
    pe_set = 1'b0;
    fin    = 1'b0;
    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    was_cap = (cap_left != 0);
    if (was_cap) begin
      cap_buf.push_back(word);
      cap_left--;
      if (cap_left == 0) begin
        fin = 1'b1;
        foreach (cap_buf[i]) exp_q.push_back(cap_buf[i]);
        cap_buf.delete();
      end
    end
    if (nxt) begin
      if (!was_cap || fin) begin
        held = (exp_q.size() + FB - 1) / FB;
        if (held < 2) cap_left = FB;
        else ov_set = 1'b1;
      end else begin
        pe_set = 1'b1;
      end
    end
    m_ovf = ov_set || (m_ovf && !clr);
    m_pe  = pe_set || (m_pe && !clr);
  endtask

  task automatic compare_all();
    int sz;
    sz = exp_q.size();
    check("out_valid", W'(bus.out_valid), W'(sz != 0));
    check("frames_avail", W'(bus.frames_avail), W'((sz + FB - 1) / FB));
    check("overflow", W'(bus.overflow), W'(m_ovf));
    check("proto_err", W'(bus.proto_err), W'(m_pe));
    if (sz != 0) begin
      check("out_data", bus.out_data, exp_q[0]);
      check("out_last", W'(bus.out_last), W'((sz % FB) == 1));
    end else begin
      check("out_last_idle", W'(bus.out_last), W'(0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit nxt, input bit rdy, input bit clr, input bit rst);
    logic [W-1:0] word;
    logic [15:0]  tag;
    bus.next_out  = nxt;
    bus.out_ready = rdy;
    bus.err_clr   = clr;
    reset         = rst;
    if (rand_y) begin
      bus.Y0 = 16'($urandom);
      bus.Y1 = 16'($urandom);
      bus.Y2 = 16'($urandom);
      bus.Y3 = 16'($urandom);
    end else begin
      tag    = frame_no << 12;
      bus.Y0 = beat_ctr ^ tag;
      bus.Y1 = (beat_ctr + 16'h0100) ^ tag;
      bus.Y2 = (beat_ctr + 16'h0200) ^ tag;
      bus.Y3 = (beat_ctr + 16'h0300) ^ tag;
    end
    word = {bus.Y3, bus.Y2, bus.Y1, bus.Y0};
    @(posedge clk);
    model_step(nxt, rdy, clr, rst, word);
    if (nxt) begin
      beat_ctr = 16'd0;
      frame_no = frame_no + 16'd1;
    end else begin
      beat_ctr = beat_ctr + 16'd1;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, 1'b0);
  endtask

  // Two frames captured back to back with the consumer stalled.
  task automatic hold_two();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(17, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rand_y   = 1'b0;
    beat_ctr = 16'd0;
    frame_no = 16'd0;
    cap_left = 0;
    m_ovf    = 1'b0;
    m_pe     = 1'b0;
    reset         = 1'b1;
    bus.next_out  = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    bus.Y0 = '0; bus.Y1 = '0; bus.Y2 = '0; bus.Y3 = '0;

    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", W'(bus.out_valid), W'(0));
    check("rst_avail", W'(bus.frames_avail), W'(0));

    // Single frame, consumer always ready.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(16, 1'b1);
    check("single_valid_rise", W'(bus.out_valid), W'(1));
    idle(20, 1'b1);
    check("single_drained", W'(bus.frames_avail), W'(0));

    // Back-to-back frames, stalled consumer, then full drain.
    hold_two();
    check("b2b_avail", W'(bus.frames_avail), W'(2));
    idle(32, 1'b1);
    check("b2b_ovf", W'(bus.overflow), W'(0));

    // Overflow with two frames held, then drain and clear.
    hold_two();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    check("ovf_set", W'(bus.overflow), W'(1));
    idle(32, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", W'(bus.overflow), W'(0));

    // Last-word pop coincident with a new start.
    hold_two();
    idle(15, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("coin_avail1", W'(bus.frames_avail), W'(1));
    idle(20, 1'b0);
    check("coin_avail2", W'(bus.frames_avail), W'(2));
    check("coin_ovf", W'(bus.overflow), W'(0));
    idle(40, 1'b1);

    // next_out mid-frame.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(12, 1'b1);
    check("proto_set", W'(bus.proto_err), W'(1));
    idle(20, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a capture, then a fresh frame.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_valid", W'(bus.out_valid), W'(0));
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(36, 1'b1);

    // Random traffic.
    rand_y = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
